// File: rtl/sme_feeder.sv
// Purpose : buffers one string/pattern record from a byte stream, replays it to SME as a gap-free burst, returns SME's answer.
// Latency : first character is one cycle after the in_last byte; result is one cycle after sme_valid, or TIMEOUT cycles after WAIT entry.
// Backpr. : in_ready is low from the end of a record until the result handshake; the result is held until res_ready.
//
// Ports
//   clk, reset                 : single clock, asynchronous active-low reset
//   in_valid/in_ready          : record byte handshake; in_char, in_kind (first byte only), in_last
//   chardata/isstring/ispattern: character burst towards SME
//   sme_valid/match/match_index: SME answer, looked at only while waiting for it
//   res_valid/res_ready        : held result handshake; res_match, res_index, res_timeout, res_overflow
//   busy                       : high unless idle in LOAD with nothing buffered
module sme_feeder #(
    parameter int DEPTH   = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_char,
    input  logic       in_kind,
    input  logic       in_last,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       sme_valid,
    input  logic       sme_match,
    input  logic [4:0] sme_match_index,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       res_timeout,
    output logic       res_overflow,
    output logic       busy
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [LW-1:0] LEN_FULL = LW'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [AW-1:0] ADDR0    = '0;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SEND   = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [LW-1:0] len;
    logic [LW-1:0] idx;
    logic          kind;
    logic          ovf;
    logic [CW-1:0] cnt;

    logic accept;
    logic store;
    logic first;
    logic cur_kind;

    assign accept   = in_valid & in_ready;
    // Bytes beyond DEPTH are still accepted but never written.
    assign store    = accept & (len != LEN_FULL);
    // len only returns to 0 between records, so it marks the first byte.
    assign first    = (len == '0);
    // A one-byte record is replayed in the same edge its kind is latched.
    assign cur_kind = first ? in_kind : kind;

    // Record buffer: contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (store) begin
            mem[len[AW-1:0]] <= in_char;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= LOAD;
            len          <= '0;
            idx          <= '0;
            kind         <= 1'b0;
            ovf          <= 1'b0;
            cnt          <= '0;
            in_ready     <= 1'b0;
            chardata     <= 8'd0;
            isstring     <= 1'b0;
            ispattern    <= 1'b0;
            res_valid    <= 1'b0;
            res_match    <= 1'b0;
            res_index    <= 5'd0;
            res_timeout  <= 1'b0;
            res_overflow <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    busy     <= (len != '0);
                    if (accept) begin
                        busy <= 1'b1;
                        if (first) begin
                            kind <= in_kind;
                        end
                        if (store) begin
                            len <= len + LW'(1);
                        end else begin
                            ovf <= 1'b1;
                        end
                        if (in_last) begin
                            // Launch character 0 now so the burst starts
                            // the cycle after the last byte; if that byte
                            // is also byte 0 it bypasses the buffer.
                            state     <= SEND;
                            in_ready  <= 1'b0;
                            chardata  <= first ? in_char : mem[ADDR0];
                            isstring  <= ~cur_kind;
                            ispattern <= cur_kind;
                            idx       <= LW'(1);
                        end
                    end
                end

                SEND: begin
                    if (idx < len) begin
                        chardata <= mem[idx[AW-1:0]];
                        idx      <= idx + LW'(1);
                    end else begin
                        // chardata keeps the last character on purpose.
                        isstring  <= 1'b0;
                        ispattern <= 1'b0;
                        idx       <= '0;
                        if (kind) begin
                            state <= WAIT;
                            cnt   <= '0;
                        end else begin
                            // ovf survives so the following pattern reports it.
                            state    <= LOAD;
                            len      <= '0;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                        end
                    end
                end

                WAIT: begin
                    if (sme_valid) begin
                        state        <= RESULT;
                        res_valid    <= 1'b1;
                        res_match    <= sme_match;
                        res_index    <= sme_match ? sme_match_index : 5'd0;
                        res_timeout  <= 1'b0;
                        res_overflow <= ovf;
                    end else if (cnt == CNT_LAST) begin
                        // The counter would reach TIMEOUT on this edge.
                        state        <= RESULT;
                        res_valid    <= 1'b1;
                        res_match    <= 1'b0;
                        res_index    <= 5'd0;
                        res_timeout  <= 1'b1;
                        res_overflow <= ovf;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                RESULT: begin
                    if (res_ready) begin
                        state     <= LOAD;
                        res_valid <= 1'b0;
                        len       <= '0;
                        ovf       <= 1'b0;
                        cnt       <= '0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sme_feeder.sv
module tb_sme_feeder;

    localparam int DEPTH   = 32;
    localparam int TIMEOUT = 16;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic       m;
        logic [4:0] ix;
        logic       to;
        logic       ov;
        int         lat;
    } res_t;
    typedef struct {
        int         d;
        logic       m;
        logic [4:0] ix;
    } plan_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_char = 8'd0;
    logic       in_kind = 1'b0;
    logic       in_last = 1'b0;
    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic       sme_valid = 1'b0;
    logic       sme_match = 1'b0;
    logic [4:0] sme_match_index = 5'd0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic       res_match;
    logic [4:0] res_index;
    logic       res_timeout;
    logic       res_overflow;
    logic       busy;

    sme_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
        .in_kind(in_kind), .in_last(in_last),
        .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
        .sme_valid(sme_valid), .sme_match(sme_match), .sme_match_index(sme_match_index),
        .res_valid(res_valid), .res_ready(res_ready), .res_match(res_match),
        .res_index(res_index), .res_timeout(res_timeout), .res_overflow(res_overflow),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    bit mon_en  = 1'b0;

    // Reference model state
    logic [8:0] exp_char[$];   // {kind, char}
    int         exp_burst[$];
    res_t       exp_res[$];
    plan_t      sme_plan[$];
    bit         ovf_pend = 1'b0;
    int         w0_cyc = 0;
    int         force_hold = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic bq_t str2q(input string s);
        bq_t q;
        q = {};
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // d_sel: -2 random plan, -1 SME never answers, >=0 answer delay from WAIT entry
    task automatic send_record(input logic kind, input bq_t d, input int gap, input bit track,
                               input int d_sel, input logic m, input logic [4:0] ix);
        int    n;
        int    nm;
        int    g;
        int    w;
        plan_t p;
        res_t  e;
        n  = d.size();
        nm = (n > DEPTH) ? DEPTH : n;
        if (track) begin
            for (int i = 0; i < nm; i++) exp_char.push_back({kind, d[i]});
            exp_burst.push_back(nm);
            if (!kind) begin
                ovf_pend = ovf_pend | (n > DEPTH);
            end else begin
                if (d_sel == -2) begin
                    p.d  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, TIMEOUT - 2));
                    p.m  = 1'($urandom);
                    p.ix = 5'($urandom);
                end else begin
                    p.d  = d_sel;
                    p.m  = m;
                    p.ix = ix;
                end
                sme_plan.push_back(p);
                e.ov = ovf_pend | (n > DEPTH);
                ovf_pend = 1'b0;
                if (p.d < 0) begin
                    e.m = 1'b0; e.ix = 5'd0; e.to = 1'b1; e.lat = TIMEOUT;
                end else begin
                    e.m = p.m; e.ix = p.m ? p.ix : 5'd0; e.to = 1'b0; e.lat = p.d + 1;
                end
                exp_res.push_back(e);
            end
        end
        for (int i = 0; i < n; i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            repeat (g) begin
                in_valid = 1'b0;
                in_char  = 8'($urandom);
                in_kind  = 1'($urandom);
                in_last  = 1'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_char  = d[i];
            in_kind  = (i == 0) ? kind : 1'($urandom);
            in_last  = (i == n - 1);
            w = 0;
            while (!in_ready && w < 600) begin
                @(negedge clk);
                w++;
            end
            if (!in_ready) fail("in_ready_wait_expired");
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((exp_char.size() != 0 || exp_burst.size() != 0 || exp_res.size() != 0 ||
                busy || res_valid) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 3000) fail("idle_wait_expired");
        @(negedge clk);
    endtask

    // Character burst monitor
    int         run = 0;
    logic [8:0] ec;
    always @(negedge clk) begin
        if (!reset || !mon_en) begin
            run = 0;
        end else if (isstring || ispattern) begin
            chk("strobe_onehot", {31'd0, isstring & ispattern}, 0);
            chk("send_in_ready", {31'd0, in_ready}, 0);
            if (exp_char.size() == 0) begin
                fail("unexpected_char");
            end else begin
                ec = exp_char.pop_front();
                chk("chardata", {24'd0, chardata}, {24'd0, ec[7:0]});
                chk("strobe_kind", {31'd0, ispattern}, {31'd0, ec[8]});
            end
            run++;
        end else if (run > 0) begin
            if (exp_burst.size() == 0) fail("unexpected_burst");
            else chk("burst_len", run, exp_burst.pop_front());
            run = 0;
        end
    end

    // SME behavioural responder
    bit    prev_pat = 1'b0;
    bit    wait_act = 1'b0;
    int    wcnt = 0;
    plan_t cur;
    always @(negedge clk) begin
        sme_valid       = 1'b0;
        sme_match       = 1'($urandom);
        sme_match_index = 5'($urandom);
        if (!reset) begin
            wait_act = 1'b0;
        end else begin
            if (mon_en && prev_pat && !ispattern) begin
                if (sme_plan.size() == 0) begin
                    fail("unexpected_wait_entry");
                end else begin
                    cur      = sme_plan.pop_front();
                    wait_act = 1'b1;
                    wcnt     = 0;
                    w0_cyc   = cyc;
                end
            end
            if (wait_act) begin
                if (wcnt == cur.d) begin
                    sme_valid       = 1'b1;
                    sme_match       = cur.m;
                    sme_match_index = cur.ix;
                    wait_act        = 1'b0;
                end else if (wcnt >= TIMEOUT - 1) begin
                    wait_act = 1'b0;
                end else begin
                    wcnt++;
                end
            end else if ((isstring || ispattern || res_valid) && $urandom_range(0, 2) == 0) begin
                // Junk answers while sending or holding a result must be ignored.
                sme_valid = 1'b1;
            end
        end
        prev_pat = ispattern;
    end

    // Result monitor and consumer
    res_t       er;
    logic [7:0] snap;
    bit         prev_rv = 1'b0;
    bit         hs = 1'b0;
    int         hold = 0;
    always @(negedge clk) begin
        if (!reset) begin
            prev_rv   = 1'b0;
            hs        = 1'b0;
            res_ready = 1'b0;
        end else begin
            if (hs) begin
                chk("hs_res_valid_drop", {31'd0, res_valid}, 0);
                chk("hs_in_ready_rise", {31'd0, in_ready}, 1);
                chk("hs_busy_clear", {31'd0, busy}, 0);
                hs = 1'b0;
            end
            if (res_valid) begin
                chk("result_in_ready", {31'd0, in_ready}, 0);
                if (!prev_rv) begin
                    if (exp_res.size() == 0) begin
                        fail("unexpected_result");
                    end else begin
                        er = exp_res.pop_front();
                        chk("res_match", {31'd0, res_match}, {31'd0, er.m});
                        chk("res_index", {27'd0, res_index}, {27'd0, er.ix});
                        chk("res_timeout", {31'd0, res_timeout}, {31'd0, er.to});
                        chk("res_overflow", {31'd0, res_overflow}, {31'd0, er.ov});
                        chk("res_latency", cyc - w0_cyc, er.lat);
                    end
                    snap = {res_match, res_index, res_timeout, res_overflow};
                    hold = (force_hold >= 0) ? force_hold : int'($urandom_range(0, 4));
                    force_hold = -1;
                end else begin
                    chk("res_stable", {24'd0, res_match, res_index, res_timeout, res_overflow},
                        {24'd0, snap});
                end
                if (hold > 0) begin
                    res_ready = 1'b0;
                    hold--;
                end else begin
                    res_ready = 1'b1;
                end
                hs = res_ready;
            end else begin
                res_ready = 1'($urandom);
            end
            prev_rv = res_valid;
        end
    end

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog_expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t q;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        chk("rst_isstring", {31'd0, isstring}, 0);
        chk("rst_ispattern", {31'd0, ispattern}, 0);
        chk("rst_chardata", {24'd0, chardata}, 0);
        chk("rst_res_valid", {31'd0, res_valid}, 0);
        chk("rst_res_fields", {24'd0, res_match, res_index, res_timeout, res_overflow}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", {31'd0, in_ready}, 1);
        mon_en = 1'b1;

        // Pattern with no preceding string, single byte
        send_record(1'b1, str2q("q"), 0, 1'b1, 2, 1'b0, 5'd7);
        // "abc" then "b"; SME answers 3 cycles after WAIT entry
        send_record(1'b0, str2q("abc"), 0, 1'b1, 0, 1'b0, 5'd0);
        send_record(1'b1, str2q("b"), 0, 1'b1, 3, 1'b1, 5'd1);
        // Stalling source: in_valid toggles every cycle
        send_record(1'b0, str2q("hello"), 1, 1'b1, 0, 1'b0, 5'd0);
        // SME never answers
        send_record(1'b1, str2q("xy"), 0, 1'b1, -1, 1'b0, 5'd0);
        // Overflowing string carried to the next pattern only
        q = {};
        for (int i = 0; i < 40; i++) q.push_back(8'($urandom));
        send_record(1'b0, q, -1, 1'b1, 0, 1'b0, 5'd0);
        send_record(1'b1, str2q("zz"), 0, 1'b1, 5, 1'b1, 5'd9);
        send_record(1'b1, str2q("zz"), 0, 1'b1, TIMEOUT - 2, 1'b1, 5'd31);
        // Exactly DEPTH is not an overflow; DEPTH+1 is
        q = {};
        for (int i = 0; i < DEPTH; i++) q.push_back(8'($urandom));
        send_record(1'b1, q, 0, 1'b1, 1, 1'b1, 5'd4);
        q.push_back(8'h55);
        send_record(1'b1, q, 0, 1'b1, 1, 1'b0, 5'd4);

        // Result held for 5 cycles, accepted in the 6th
        wait_idle();
        force_hold = 5;
        send_record(1'b1, str2q("k"), 0, 1'b1, 0, 1'b1, 5'd2);
        wait_idle();

        // Reset in the second SEND cycle
        mon_en = 1'b0;
        send_record(1'b0, str2q("wxyz"), 0, 1'b0, 0, 1'b0, 5'd0);
        chk("rst_mid_pre_strobe", {31'd0, isstring}, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_mid_isstring", {31'd0, isstring}, 0);
        chk("rst_mid_ispattern", {31'd0, ispattern}, 0);
        chk("rst_mid_in_ready", {31'd0, in_ready}, 0);
        chk("rst_mid_busy", {31'd0, busy}, 0);
        @(negedge clk);
        reset    = 1'b1;
        ovf_pend = 1'b0;
        @(negedge clk);
        chk("rst_mid_in_ready_back", {31'd0, in_ready}, 1);
        mon_en = 1'b1;
        send_record(1'b0, str2q("fresh"), 0, 1'b1, 0, 1'b0, 5'd0);
        send_record(1'b1, str2q("re"), 0, 1'b1, 2, 1'b1, 5'd3);

        // Randomized records
        for (int r = 0; r < 30; r++) begin
            q = {};
            for (int j = 0; j < (($urandom_range(0, 4) == 0) ? int'($urandom_range(30, 40))
                                                              : int'($urandom_range(1, 8))); j++)
                q.push_back(8'($urandom));
            if (q.size() == 0) q.push_back(8'h41);
            send_record(1'($urandom), q, -1, 1'b1, -2, 1'b0, 5'd0);
        end

        wait_idle();
        chk("leftover_chars", exp_char.size(), 0);
        chk("leftover_results", exp_res.size(), 0);
        chk("leftover_sme_plans", sme_plan.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/sme_feeder.md
# sme_feeder

Hardware front end for the SME string-matching engine. Accepts string and pattern records as a byte stream with valid/ready flow control and buffers each record completely. Replays the record to SME as one contiguous burst on `chardata`/`isstring`/`ispattern`, then waits for SME's `valid` and returns match/index (or a timeout) on a held result handshake. It lets SME be driven from a stallable source instead of a cycle-exact bench.

## Interface
- `DEPTH`, 32: record buffer size in bytes; maximum characters sent per record (matches the 5-bit index range).
- `TIMEOUT`, 1023: cycles spent waiting for SME `valid` before a timeout result is declared.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input byte present.
- `in_ready`  out  1  feeder accepts a byte this cycle.
- `in_char`  in  8  record byte.
- `in_kind`  in  1  0 = string, 1 = pattern; sampled on the first byte of a record only.
- `in_last`  in  1  marks the final byte of the record.
- `chardata`  out  8  character to SME.
- `isstring`  out  1  string character strobe to SME.
- `ispattern`  out  1  pattern character strobe to SME.
- `sme_valid`  in  1  SME result valid.
- `sme_match`  in  1  SME match flag.
- `sme_match_index`  in  5  SME match position.
- `res_valid`  out  1  result available; held until accepted.
- `res_ready`  in  1  result consumer ready.
- `res_match`  out  1  match flag, forced to 0 on timeout.
- `res_index`  out  5  match index, forced to 0 when `res_match`=0.
- `res_timeout`  out  1  SME did not answer within `TIMEOUT`.
- `res_overflow`  out  1  the pattern, or the string preceding it, exceeded `DEPTH`.
- `busy`  out  1  high in any state other than LOAD with an empty buffer.

## Operation
- States are LOAD, SEND, WAIT and RESULT. Reset enters LOAD.
- **LOAD**
  - `in_ready`=1.
  - Each accepted byte (`in_valid`&`in_ready`) is written at `buf[len]` and `len` increments.
  - `kind` is latched from the first byte of the record.
  - Bytes arriving after `len`=`DEPTH` are dropped but still accepted, and they set `ovf`.
  - Accepting the byte with `in_last` moves the block to SEND.
- **SEND**
  - `in_ready`=0.
  - For `len` consecutive cycles: `chardata`=`buf[i]`, `isstring`=~`kind`, `ispattern`=`kind`, with `i` running 0..`len`-1.
  - After the last character, a string returns to LOAD and a pattern goes to WAIT.
  - Strings clear `len`. `ovf` from a string is carried over so it is reported with the next pattern's result.
- **WAIT**
  - `isstring`=`ispattern`=0 and `in_ready`=0.
  - A timeout counter starts at 0.
  - `sme_valid`=1 captures `sme_match`/`sme_match_index` and moves to RESULT.
  - If the counter reaches `TIMEOUT`, the block moves to RESULT with `res_timeout`=1 and `res_match`=0.
  - `sme_valid` is ignored in every other state.
- **RESULT**
  - `res_*` are driven and held stable.
  - On `res_valid`&`res_ready` the block clears `len`, `ovf` and the timeout counter, then goes to LOAD.
- A record is always at least 1 byte, because `in_last` travels with a byte.
- A pattern with no prior string is still sent unchanged.
- `chardata` holds its last value when no strobe is active.
- Reset values: every output is 0 (`in_ready`=0 while reset is asserted). The buffer contents are don't-care.
- Reset mid-operation: strobes and `res_valid` drop immediately (asynchronously), and the record in progress is discarded.

## Timing
- All outputs are registered.
- The first SEND character appears in the cycle after the `in_last` byte is accepted.
- Strobes are contiguous for exactly `len` cycles, with no gaps regardless of input stalls.
- The strobe deasserts in the cycle after the last character.
- A string record occupies `len` cycles of SEND. `in_ready` returns 1 in the cycle after its final character.
- WAIT begins in the cycle after the last pattern character. `sme_valid` is sampled from that cycle onward.
- `res_valid` rises in the cycle after `sme_valid` is sampled, or `TIMEOUT` cycles after WAIT entry.
- `in_ready` rises in the cycle after the result handshake.
- Counters: `len`/`i` are 6 bits (so 0..`DEPTH` is representable); the timeout counter is 10 bits by default (ceil(log2(`TIMEOUT`+1))).

## Test plan
- String "abc", then pattern "b"; SME model returns valid=1, match=1, index=1 three cycles after WAIT entry -> `isstring` high for exactly 3 cycles carrying 'a','b','c'; `ispattern` high for 1 cycle carrying 'b'; `res_valid`=1 with match=1, index=1, timeout=0.
- String "hello" with `in_valid` toggling every cycle -> `isstring` still high for 5 consecutive cycles, in order h,e,l,l,o.
- `TIMEOUT`=16; SME never asserts valid -> `res_valid` 16 cycles after WAIT entry with timeout=1, match=0, index=0.
- 40-byte string, then 2-byte pattern -> `isstring` high for 32 cycles only; the pattern's result has `res_overflow`=1; the next result has `res_overflow`=0.
- `res_ready` held low for 5 cycles -> `res_valid` and all `res_*` stable, `in_ready`=0; the handshake in cycle 6 returns the block to LOAD.
- `reset` asserted during the 2nd SEND cycle -> strobes go to 0 immediately; after release `in_ready`=1 and a fresh record is sent correctly.
